// File: rtl/rv_program_loader.sv
// Packs RV32I instruction fields into machine words and writes them sequentially into
// instruction memory, holding the core in reset until the whole program is loaded.
module rv_program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              crst_q, crst_d;

  logic [31:0] enc;
  logic [6:0]  f7;
  logic        fmt_bad;

  always_comb begin
    f7  = {1'b0, in_funct7b5, 5'b0};
    enc = '0;
    case (in_fmt)
      3'd0: enc = {f7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      3'd1: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      3'd2: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      3'd3: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                   in_imm[11], in_op};
      3'd4: enc = {in_imm[31:12], in_rd, in_op};
      3'd5: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      default: enc = '0;
    endcase
    // Branch/jump targets are halfword aligned; an odd byte offset cannot be encoded.
    fmt_bad = (in_fmt > 3'd5) || (((in_fmt == 3'd3) || (in_fmt == 3'd5)) && in_imm[0]);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    word_d  = word_q;
    last_d  = last_q;
    done_d  = done_q;
    err_d   = err_q;
    crst_d  = crst_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          addr_d  = '0;
          count_d = '0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (fmt_bad) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            word_d  = enc;
            last_d  = in_last;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        count_d = count_q + (ADDR_W+1)'(1);
        addr_d  = addr_q + ADDR_W'(1);
        if (last_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          crst_d  = 1'b1;
        end else if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          state_d = StLoad;
        end
      end
      StDone, StErr: begin
        if (start) begin
          state_d = StLoad;
          done_d  = 1'b0;
          err_d   = 1'b0;
          crst_d  = 1'b0;
          addr_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      word_q  <= word_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
    end
  end

  // Strobe decoded straight from state so an asynchronous reset kills it at once.
  assign in_ready   = (state_q == StLoad);
  assign imem_we    = (state_q == StWrite);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign core_rst_n = crst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_rv_program_loader.sv
// Self-checking bench for rv_program_loader: directed scenarios plus randomized programs
// compared against a field-arithmetic encoder model and an expected write list.
module tb_rv_program_loader;

  localparam int unsigned AW = 2;

  logic          clk, rst_n, start, in_valid, in_ready;
  logic [2:0]    in_fmt, in_funct3;
  logic [6:0]    in_op;
  logic          in_funct7b5, in_last;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          imem_we, core_rst_n, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  rv_program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .done(done), .err(err), .count(count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wr_data[$];
  int          wr_addr[$];
  logic [31:0] exp_q[$];
  int          consec_we = 0;
  logic        prev_we   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
    end
    if (imem_we && prev_we) consec_we++;
    prev_we = imem_we;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(input logic [2:0] fmt, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] f7b5, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    w = op;
    case (fmt)
      3'd0: w = w + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7b5 << 30);
      3'd1: w = w + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 32'hfff) << 20);
      3'd2: w = w + ((imm & 31) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
                + (((imm >> 5) & 127) << 25);
      3'd3: w = w + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8) + (f3 << 12)
                + (rs1 << 15) + (rs2 << 20) + (((imm >> 5) & 63) << 25)
                + (((imm >> 12) & 1) << 31);
      3'd4: w = w + (rd << 7) + (imm & 32'hfffff000);
      default: w = w + (rd << 7) + (imm & 32'h000ff000) + (((imm >> 11) & 1) << 20)
                   + (((imm >> 1) & 1023) << 21) + (((imm >> 20) & 1) << 31);
    endcase
    return w;
  endfunction

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic f7b5, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic last);
    in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7b5 = f7b5;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  // Presents the current fields until accepted (bounded), returns #1 after the accept edge.
  task automatic send();
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("accept_ready", in_ready, 1);
    if (in_ready) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_data.delete();
    wr_addr.delete();
    exp_q.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_data.size(), exp_q.size());
    for (int i = 0; i < wr_data.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, wr_addr[i], i);
      check({tag, "_data"}, wr_data[i], exp_q[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_crst"}, core_rst_n, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_count"}, count, 0);
  endtask

  initial begin
    logic [2:0]  fmt;
    logic [31:0] imm, w;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd, rs1, rs2;
    int          n, ngood, gap, ready_low;
    bit          bad;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    set_fields(3'd0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    #3;
    check_reset_outputs("reset");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // addi then add; bundle presented together with start in IDLE
    set_fields(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    in_valid = 1'b1;
    pulse_start();
    check("start_valid_nowrite", wr_data.size(), 0);
    check("start_valid_ready", in_ready, 1);
    send();
    set_fields(3'd0, 7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    send();
    @(posedge clk); #1;
    exp_q.push_back(32'h00500093);
    exp_q.push_back(32'h002081B3);
    check_writes("prog1");
    check("prog1_done", done, 1);
    check("prog1_count", count, 2);
    check("prog1_crst", core_rst_n, 1);

    // sw, beq, jal
    pulse_start();
    check("restart_done_clr", done, 0);
    check("restart_crst_clr", core_rst_n, 0);
    set_fields(3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send();
    set_fields(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
    send();
    set_fields(3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
    send();
    @(posedge clk); #1;
    exp_q.push_back(32'h0020A423);
    exp_q.push_back(32'hFE208EE3);
    exp_q.push_back(32'h008000EF);
    check_writes("sbj");
    check("sbj_done", done, 1);

    // illegal format aborts with no write, then a restart recovers
    pulse_start();
    set_fields(3'd6, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    send();
    @(posedge clk); #1;
    check("illegal_err", err, 1);
    check("illegal_nowrite", wr_data.size(), 0);
    check("illegal_crst", core_rst_n, 0);
    pulse_start();
    check("illegal_err_clr", err, 0);
    set_fields(3'd4, 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b1);
    send();
    @(posedge clk); #1;
    exp_q.push_back(32'h123453B7);
    check_writes("recover");
    check("recover_done", done, 1);

    // overflow: fifth bundle never accepted
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      set_fields(3'd1, 7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
      send();
      exp_q.push_back(ref_enc(3'd1, 32'h13, 0, 0, i + 1, 0, 0, i));
    end
    set_fields(3'd1, 7'h13, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0);
    in_valid = 1'b1;
    ready_low = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!in_ready) ready_low++;
    end
    in_valid = 1'b0;
    check_writes("ovf");
    check("ovf_err", err, 1);
    check("ovf_count", count, 4);
    check("ovf_ready_low", ready_low, 5);

    // in_valid gap mid-stream
    pulse_start();
    set_fields(3'd1, 7'h13, 3'd1, 1'b0, 5'd2, 5'd3, 5'd0, 32'd77, 1'b0);
    send();
    exp_q.push_back(ref_enc(3'd1, 32'h13, 1, 0, 2, 3, 0, 77));
    @(posedge clk); #1;
    ready_low = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!in_ready) ready_low++;
    end
    check("gap_ready", ready_low, 0);
    check("gap_nwr", wr_data.size(), 1);
    set_fields(3'd0, 7'h33, 3'd5, 1'b1, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0);
    send();
    exp_q.push_back(ref_enc(3'd0, 32'h33, 5, 1, 4, 5, 6, 0));
    set_fields(3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd8, 5'd9, 32'hFFFFFFF0, 1'b1);
    send();
    exp_q.push_back(ref_enc(3'd2, 32'h23, 2, 0, 0, 8, 9, 32'hFFFFFFF0));
    @(posedge clk); #1;
    check_writes("gap");
    check("gap_count", count, 3);

    // asynchronous reset during the third write
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      set_fields(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
      send();
    end
    check("rst_mid_we_before", imem_we, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_nwr", wr_data.size(), 2);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_idle_ready", in_ready, 0);

    // randomized programs
    for (int t = 0; t < 40; t++) begin
      pulse_start();
      n = $urandom_range(1, 4);
      ngood = 0;
      bad = 1'b0;
      for (int i = 0; i < n && !bad; i++) begin
        fmt = 3'($urandom_range(0, 5));
        if ($urandom_range(0, 11) == 0) fmt = 3'($urandom_range(6, 7));
        imm = $urandom;
        if ((fmt == 3'd3 || fmt == 3'd5) && $urandom_range(0, 7) != 0) imm[0] = 1'b0;
        op = 7'($urandom); f3 = 3'($urandom); f7b5 = 1'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        set_fields(fmt, op, f3, f7b5, rd, rs1, rs2, imm, i == n - 1);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
        send();
        bad = (fmt > 3'd5) || ((fmt == 3'd3 || fmt == 3'd5) && imm[0]);
        if (!bad) begin
          w = ref_enc(fmt, 32'(op), 32'(f3), 32'(f7b5), 32'(rd), 32'(rs1), 32'(rs2), imm);
          exp_q.push_back(w);
          ngood++;
        end
      end
      @(posedge clk); #1;
      check_writes("rnd");
      check("rnd_done", done, !bad);
      check("rnd_err", err, bad);
      check("rnd_crst", core_rst_n, !bad);
      check("rnd_count", count, ngood);
    end

    check("we_consecutive", consec_we, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_program_loader.md
# rv_program_loader

Sequential instruction encoder and program loader for the RISC-V single-cycle core. It accepts instruction fields (format, opcode, funct3, funct7b5, registers, immediate) over a valid/ready stream and packs them into RV32I R/I/S/B/U/J machine words. The words are written sequentially into instruction memory from word address 0. The core is held in reset until the whole program is loaded. This block produces the fields that the core's control decoder later pulls back out of the fetched word.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 2**ADDR_W, number of writable words

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that starts or restarts a load
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader can accept a bundle
- in_fmt  in  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
- in_op  in  7  opcode
- in_funct3  in  3  funct3
- in_funct7b5  in  1  funct7 bit 5 (R format only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate, byte offset for B and J
- in_last  in  1  marks the final instruction of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- core_rst_n  out  1  active-low reset to the core
- done  out  1  load completed
- err  out  1  load aborted
- count  out  ADDR_W+1  number of words written

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, done=0, err=0, count=0.
- IDLE: start -> LOAD; address and count are cleared.
- LOAD: in_ready=1. On in_valid&in_ready, the encoded word and the last flag are registered, then the FSM goes to WRITE.
  - If the format is illegal, the FSM goes to ERR and nothing is written.
  - If the format is B or J and in_imm[0]=1, the FSM goes to ERR and nothing is written.
- WRITE: in_ready=0. imem_we=1 for exactly one cycle, with imem_addr=current address and imem_wdata=registered word. Then count increments and the address increments.
  - If last is set: -> DONE.
  - Else if the address was DEPTH-1: -> ERR (overflow; the word is still written).
  - Else: -> LOAD.
- DONE: done=1, core_rst_n=1.
- ERR: err=1, core_rst_n=0.
- start in DONE or ERR: done=0, err=0, core_rst_n=0, address=0, count=0, -> LOAD.
- start in LOAD or WRITE is ignored.
- Encodings, where f7 = {1'b0, in_funct7b5, 5'b0}:
  - R: {f7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}. The caller sets imm[10] for srai.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Immediate bits outside each format's field are ignored; no range check is performed.

## Timing
- Throughput is one instruction per 2 cycles: the accept edge, then the write cycle.
- imem_we rises the cycle after acceptance and is never asserted on two consecutive cycles.
- Once asserted, in_valid must be held with stable fields until accepted.
- core_rst_n rises on the same edge that enters DONE. done and core_rst_n are registered outputs.
- rst_n assertion mid-load returns all outputs to their reset values immediately, without waiting for a clock edge. imem_we drops at once; the partial image is abandoned.
- start and in_valid arriving together in IDLE: only start acts; the bundle is accepted on the next LOAD cycle.

## Test plan
- Load addi x1,x0,5 (I, op 0x13, imm 5), then add x3,x1,x2 (R, op 0x33, in_last=1) -> mem[0]=0x00500093 and mem[1]=0x002081B3. done=1, count=2, core_rst_n=1.
- S/B/J encodings:
  - sw x2,8(x1) (f3=2) -> 0x0020A423
  - beq x1,x2,-4 -> 0xFE208EE3
  - jal x1,8 -> 0x008000EF
- in_fmt=6 in LOAD -> err=1, no imem_we pulse, core_rst_n stays 0. Then start and a single in_last bundle -> ERR clears and mem[0] is written.
- With ADDR_W=2, stream 5 bundles with in_last=0 -> 4 writes (addresses 0..3), then err=1 and count=4.
- Drop rst_n during WRITE of the 3rd word -> all outputs return to reset values immediately.
- Hold in_valid low for 10 cycles mid-stream -> no writes occur and in_ready stays 1; resume -> addresses continue without gaps.
